// File: rtl/nv_fifo_ctrl_16x272.sv
// nv_fifo_ctrl_16x272
//   Valid/ready FIFO controller for a 16 x 272 two-port RAM. The RAM has a
//   synchronous write port and a registered read address (loaded on ram_re);
//   its dout is a combinational read of the stored address. The head entry
//   is held on ram_dout until it is popped, so rd_pd is simply ram_dout.
//
//   Optional feature macro: NV_FIFO_CTRL_LEVEL_EN adds fifo_level/fifo_idle.
//
// Ports
//   nvdla_core_clk, nvdla_core_rstn  clock, async active-low reset
//   wr_pvld/wr_prdy/wr_pd            producer handshake and data
//   rd_pvld/rd_prdy/rd_pd            consumer handshake and head data
//   ram_we/ram_wa/ram_di             RAM write port
//   ram_re/ram_ra/ram_dout           RAM read port
//   pwrbus_ram_pd -> ram_pwrbus_pd   power bus passthrough
//   fifo_level, fifo_idle            occupancy status (LEVEL_EN only)
module nv_fifo_ctrl_16x272 #(
  parameter int DW = 272,
  parameter int AW = 4
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
`ifdef NV_FIFO_CTRL_LEVEL_EN
  output logic [AW:0]   fifo_level,
  output logic          fifo_idle,
`endif
  output logic [31:0]   ram_pwrbus_pd
);

  localparam logic [AW:0]   DEPTH  = (AW+1)'(2**AW);
  localparam logic [AW:0]   CNT1   = (AW+1)'(1);
  localparam logic [AW-1:0] ADR1   = AW'(1);

  logic [AW-1:0] wr_adr_q, wr_adr_d;
  logic [AW-1:0] rd_adr_q, rd_adr_d;
  logic [AW:0]   count_q, count_d;
  logic          rd_pvld_q, rd_pvld_d;
  logic          wr_prdy_q, wr_prdy_d;

  logic          push, pop, load;
  logic [AW:0]   avail;

  assign push = wr_pvld & wr_prdy_q;
  assign pop  = rd_pvld_q & rd_prdy;

  // Entries sitting in the RAM that have not yet been moved onto ram_dout.
  assign avail = count_q - {{AW{1'b0}}, rd_pvld_q};

  // A same-cycle push may be loaded directly: the read address register and
  // the write land on the same edge, so dout shows the new word next cycle.
  assign load = ((avail != '0) | push) & (!rd_pvld_q | rd_prdy);

  always_comb begin
    wr_adr_d  = wr_adr_q;
    rd_adr_d  = rd_adr_q;
    count_d   = count_q;
    rd_pvld_d = rd_pvld_q;

    if (push) wr_adr_d = wr_adr_q + ADR1;
    if (load) rd_adr_d = rd_adr_q + ADR1;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT1;
      2'b01:   count_d = count_q - CNT1;
      default: count_d = count_q;
    endcase

    if (load)     rd_pvld_d = 1'b1;
    else if (pop) rd_pvld_d = 1'b0;

    // Registered ready: a pop while full only frees space from the next cycle.
    wr_prdy_d = (count_d != DEPTH);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_adr_q  <= '0;
      rd_adr_q  <= '0;
      count_q   <= '0;
      rd_pvld_q <= 1'b0;
      wr_prdy_q <= 1'b0;
    end else begin
      wr_adr_q  <= wr_adr_d;
      rd_adr_q  <= rd_adr_d;
      count_q   <= count_d;
      rd_pvld_q <= rd_pvld_d;
      wr_prdy_q <= wr_prdy_d;
    end
  end

  assign wr_prdy       = wr_prdy_q;
  assign rd_pvld       = rd_pvld_q;
  assign rd_pd         = ram_dout;
  assign ram_we        = push;
  assign ram_wa        = wr_adr_q;
  assign ram_di        = wr_pd;
  assign ram_re        = load;
  assign ram_ra        = rd_adr_q;
  assign ram_pwrbus_pd = pwrbus_ram_pd;

`ifdef NV_FIFO_CTRL_LEVEL_EN
  assign fifo_level = count_q;
  assign fifo_idle  = (count_q == '0) & !wr_pvld;
`endif

endmodule

// File: tb/tb_nv_fifo_ctrl_16x272.sv
// Bench for nv_fifo_ctrl_16x272: behavioural RAM plus a queue-based
// reference model of FIFO contents; directed phases then random traffic.
module tb_nv_fifo_ctrl_16x272;

  localparam int DW = 272;
  localparam int AW = 4;

  logic          clk;
  logic          rstn;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic [AW-1:0] ram_wa;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_dout;
  logic [31:0]   pwrbus_ram_pd;
  logic [31:0]   ram_pwrbus_pd;
`ifdef NV_FIFO_CTRL_LEVEL_EN
  logic [AW:0]   fifo_level;
  logic          fifo_idle;
`endif

  nv_fifo_ctrl_16x272 #(.DW(DW), .AW(AW)) u_dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .wr_pvld         (wr_pvld),
    .wr_prdy         (wr_prdy),
    .wr_pd           (wr_pd),
    .rd_pvld         (rd_pvld),
    .rd_prdy         (rd_prdy),
    .rd_pd           (rd_pd),
    .ram_wa          (ram_wa),
    .ram_we          (ram_we),
    .ram_di          (ram_di),
    .ram_ra          (ram_ra),
    .ram_re          (ram_re),
    .ram_dout        (ram_dout),
    .pwrbus_ram_pd   (pwrbus_ram_pd),
`ifdef NV_FIFO_CTRL_LEVEL_EN
    .fifo_level      (fifo_level),
    .fifo_idle       (fifo_idle),
`endif
    .ram_pwrbus_pd   (ram_pwrbus_pd)
  );

  // Two-port RAM: synchronous write, registered read address, async dout.
  logic [DW-1:0] mem [16];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: ordered contents, readiness after reset, push total.
  logic [DW-1:0] q[$];
  bit            model_ready;
  int unsigned   push_total;
  bit            exp_push, exp_pop;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = '0;
    for (int i = 0; i < 9; i++) d = {d[DW-33:0], 32'($urandom())};
    return d;
  endfunction

  // One clock: drive at posedge+1, check at negedge, advance model at posedge.
  task automatic step(input bit wv, input logic [DW-1:0] data, input bit rr);
    bit exp_rdy, exp_vld;
    wr_pvld = wv;
    wr_pd   = data;
    rd_prdy = rr;
    pwrbus_ram_pd = $urandom();
    @(negedge clk);
    exp_rdy  = model_ready && (q.size() != 16);
    exp_vld  = (q.size() != 0);
    exp_push = wv && exp_rdy;
    exp_pop  = exp_vld && rr;
    chk("wr_prdy", DW'(wr_prdy), DW'(exp_rdy));
    chk("rd_pvld", DW'(rd_pvld), DW'(exp_vld));
    if (exp_vld) chk("rd_pd", rd_pd, q[0]);
    chk("ram_we", DW'(ram_we), DW'(exp_push));
    if (exp_push) begin
      chk("ram_wa", DW'(ram_wa), DW'(push_total % 16));
      chk("ram_di", ram_di, data);
    end
    chk("pwrbus", DW'(ram_pwrbus_pd), DW'(pwrbus_ram_pd));
`ifdef NV_FIFO_CTRL_LEVEL_EN
    chk("fifo_level", DW'(fifo_level), DW'(q.size()));
    chk("fifo_idle", DW'(fifo_idle), DW'((q.size() == 0) && !wv));
`endif
    @(posedge clk);
    if (exp_pop) void'(q.pop_front());
    if (exp_push) begin
      q.push_back(data);
      push_total++;
    end
    model_ready = 1'b1;
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    model_ready = 1'b0;
    push_total  = 0;
  endtask

  logic [DW-1:0] a5;
  int wbias, rbias;

  initial begin
    rstn = 1'b0;
    wr_pvld = 1'b0;
    wr_pd = '0;
    rd_prdy = 1'b0;
    pwrbus_ram_pd = 32'h1234_5678;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wr_prdy", DW'(wr_prdy), DW'(0));
    chk("rst_rd_pvld", DW'(rd_pvld), DW'(0));
    @(posedge clk);
    #1 rstn = 1'b1;

    // wr_prdy stays low for the first cycle, then rises
    step(0, '0, 0);
    step(0, '0, 0);

    // Write-through into an empty FIFO
    a5 = {34{8'hA5}};
    step(1, a5, 0);
    step(0, '0, 0);
    step(0, '0, 1);
    step(0, '0, 0);

    // Fill to 16, then a 17th offer must be refused
    for (int i = 0; i < 16; i++) step(1, rand_data(), 0);
    step(1, rand_data(), 0);
    step(1, rand_data(), 0);

    // Pop one at full; ready returns next cycle, then push+pop each cycle
    step(1, rand_data(), 1);
    for (int i = 0; i < 6; i++) step(1, rand_data(), 1);

    // Drain
    for (int i = 0; i < 18; i++) step(0, '0, 1);

    // Full-rate streaming across two pointer wraps
    for (int i = 0; i < 40; i++) step(1, rand_data(), 1);
    for (int i = 0; i < 4; i++) step(0, '0, 1);

    // Reset mid-stream with five entries held
    for (int i = 0; i < 5; i++) step(1, rand_data(), 0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_wr_prdy", DW'(wr_prdy), DW'(0));
    chk("midrst_rd_pvld", DW'(rd_pvld), DW'(0));
`ifdef NV_FIFO_CTRL_LEVEL_EN
    chk("midrst_level", DW'(fifo_level), DW'(0));
`endif
    model_reset();
    @(posedge clk);
    #1 rstn = 1'b1;
    step(0, '0, 1);
    step(0, '0, 1);
    for (int i = 0; i < 8; i++) step(1, rand_data(), ($urandom() % 2) == 1);

    // Random traffic with varying pressure
    for (int blk = 0; blk < 10; blk++) begin
      wbias = 1 + (blk % 4) * 3;
      rbias = 1 + ((blk + 2) % 4) * 3;
      for (int i = 0; i < 1000; i++)
        step(($urandom() % 10) < wbias, rand_data(), ($urandom() % 10) < rbias);
    end
    for (int i = 0; i < 20; i++) step(0, '0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
